mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_copy_engine.sv | 90 +++++++++
 tb/tb_mem_copy_engine.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and
// default datapath widths.
package mem_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 16;
  localparam int unsigned DefLenW  = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRead  = 2'b01,
    StWrite = 2'b10,
    StDone  = 2'b11
  } state_e;

endpackage : mem_pkg

// File: rtl/mem_copy_engine.sv
// Word-by-word forward copy between two regions of an external single-port RAM.
// Each word costs one READ cycle and one WRITE cycle.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned LEN_W  = DefLenW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  output logic [DATA_W-1:0] ram_inp,
  input  logic [DATA_W-1:0] ram_outp
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0]   dst_ptr_q, dst_ptr_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      count_q   <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      count_q   <= count_d;
      data_q    <= data_d;
    end
  end

  // Inputs are only latched in StIdle, so a start during a copy cannot disturb it.
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    count_d   = count_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          count_d   = length;
          state_d   = (length == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        data_d  = ram_outp;
        state_d = StWrite;
      end
      StWrite: begin
        src_ptr_d = src_ptr_q + ADDR_W'(1);
        dst_ptr_d = dst_ptr_q + ADDR_W'(1);
        count_d   = count_q - LEN_W'(1);
        state_d   = (count_q == LEN_W'(1)) ? StDone : StRead;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decode the registered state only; nothing here depends on start.
  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    ram_load    = (state_q == StWrite);
    ram_address = (state_q == StWrite) ? dst_ptr_q : src_ptr_q;
    ram_inp     = data_q;
  end

endmodule : mem_copy_engine

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: external RAM model plus a forward-copy reference memory.
module tb_mem_copy_engine;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_address;
  logic          ram_load;
  logic [DW-1:0] ram_inp;
  logic [DW-1:0] ram_outp;

  logic [DW-1:0] mem     [65536];
  logic [DW-1:0] ref_mem [65536];
  logic          tb_we;
  logic [AW-1:0] tb_wa;
  logic [DW-1:0] tb_wd;

  int n_cmp;
  int n_err;
  int done_cnt;
  int load_cnt;
  int busy_cnt;

  mem_copy_engine #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .LEN_W (LW)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .ram_address(ram_address),
    .ram_load   (ram_load),
    .ram_inp    (ram_inp),
    .ram_outp   (ram_outp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(i * 7919 + 32'h1234);
  endfunction

  // Single owner of the RAM array: initial fill, DUT writes, bench setup writes.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (ram_load) mem[ram_address] <= ram_inp;
      else if (tb_we) mem[tb_wa] <= tb_wd;
    end
  end

  assign ram_outp = mem[ram_address];

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (ram_load) load_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    ref_mem[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Reference: plain forward word-by-word copy with address wrap.
  task automatic ref_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n);
    for (int i = 0; i < n; i++) ref_mem[AW'(d + AW'(i))] = ref_mem[AW'(s + AW'(i))];
  endtask

  function automatic int mem_diff();
    int c = 0;
    for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) c++;
    return c;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_load"}, 32'(ram_load), 0);
    check({tag, "_addr"}, 32'(ram_address), 0);
    check({tag, "_inp"}, 32'(ram_inp), 0);
  endtask

  // Starts a copy, optionally pokes a second start at sample 'poke', returns the
  // number of cycles from the start edge until done is seen (-1 on timeout).
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [LW-1:0] n, input int poke, output int lat);
    int limit;
    limit = 2 * int'(n) + 20;
    @(negedge clk);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    load_cnt = 0;
    busy_cnt = 0;
    #1;
    start    = 1'b0;
    src_addr = AW'($urandom);
    dst_addr = AW'($urandom);
    length   = LW'($urandom);
    lat = 1;
    while (!done && lat < limit) begin
      if (lat == poke) start = 1'b1;
      if (lat == poke + 1) start = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
  endtask

  int lat;
  logic [AW-1:0] rs, rd;
  logic [LW-1:0] rn;

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_cnt = 0;
    load_cnt = 0;
    busy_cnt = 0;
    tb_we = 1'b0;
    tb_wa = '0;
    tb_wd = '0;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    reset = 1'b1;
    #1;
    check_reset_state("rst");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic copy
    set_word(16, 16'd1111);
    set_word(17, 16'd2222);
    set_word(18, 16'd3333);
    set_word(19, 16'd4444);
    run_copy(16, 64, 4, -5, lat);
    ref_copy(16, 64, 4);
    check("basic_lat", 32'(lat), 9);
    check("basic_done_cnt", 32'(done_cnt), 1);
    check("basic_dst0", 32'(mem[64]), 1111);
    check("basic_dst3", 32'(mem[67]), 4444);
    check("basic_src1", 32'(mem[17]), 2222);
    check("basic_mem", 32'(mem_diff()), 0);

    // Zero length
    run_copy(100, 200, 0, -5, lat);
    check("zero_lat", 32'(lat), 1);
    check("zero_busy_cycles", 32'(busy_cnt), 1);
    check("zero_done_cnt", 32'(done_cnt), 1);
    check("zero_load_cnt", 32'(load_cnt), 0);
    check("zero_mem", 32'(mem_diff()), 0);

    // Address wrap
    set_word(16'hFFFE, 16'hA0A0);
    set_word(16'hFFFF, 16'hA1A1);
    set_word(16'h0000, 16'hA2A2);
    set_word(16'h0001, 16'hA3A3);
    run_copy(16'hFFFE, 16'h0100, 4, -5, lat);
    ref_copy(16'hFFFE, 16'h0100, 4);
    check("wrap_lat", 32'(lat), 9);
    check("wrap_0100", 32'(mem[16'h0100]), 32'hA0A0);
    check("wrap_0102", 32'(mem[16'h0102]), 32'hA2A2);
    check("wrap_0103", 32'(mem[16'h0103]), 32'hA3A3);
    check("wrap_mem", 32'(mem_diff()), 0);

    // Overlap: forward copy smears the first word
    set_word(8, 16'h000A);
    set_word(9, 16'h000B);
    set_word(10, 16'h000C);
    set_word(11, 16'h000D);
    run_copy(8, 9, 3, -5, lat);
    ref_copy(8, 9, 3);
    for (int i = 8; i < 12; i++) check("overlap_word", 32'(mem[i]), 32'h000A);
    check("overlap_mem", 32'(mem_diff()), 0);

    // Start while busy is ignored
    run_copy(300, 400, 2, 2, lat);
    ref_copy(300, 400, 2);
    check("busy_start_lat", 32'(lat), 5);
    check("busy_start_done_cnt", 32'(done_cnt), 1);
    check("busy_start_mem", 32'(mem_diff()), 0);

    // Reset during second WRITE
    @(negedge clk);
    src_addr = 500;
    dst_addr = 600;
    length   = 4;
    start    = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    load_cnt = 0;
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_in_write", 32'(ram_load), 1);
    reset = 1'b1;
    #1;
    check_reset_state("mid_rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ref_copy(500, 600, 1);
    check("mid_load_cnt", 32'(load_cnt), 1);
    check("mid_done_cnt", 32'(done_cnt), 0);
    check("mid_mem", 32'(mem_diff()), 0);

    // First edge after reset release with start high is accepted
    run_copy(700, 710, 3, -5, lat);
    ref_copy(700, 710, 3);
    check("post_rst_lat", 32'(lat), 7);
    check("post_rst_mem", 32'(mem_diff()), 0);

    // Randomized copies
    for (int t = 0; t < 12; t++) begin
      rs = AW'($urandom_range(0, 1023));
      rd = AW'($urandom_range(0, 1023));
      if (t % 4 == 3) rs = AW'($urandom);
      rn = LW'($urandom_range(0, 12));
      for (int i = 0; i < int'(rn); i++) set_word(AW'(rs + AW'(i)), DW'($urandom));
      run_copy(rs, rd, rn, -5, lat);
      ref_copy(rs, rd, int'(rn));
      check("rnd_lat", 32'(lat), 32'(2 * int'(rn) + 1));
      check("rnd_done_cnt", 32'(done_cnt), 1);
      check("rnd_load_cnt", 32'(load_cnt), 32'(rn));
      check("rnd_mem", 32'(mem_diff()), 0);
    end

    // Maximum length
    run_copy(16'h2000, 16'h2080, 8'hFF, -5, lat);
    ref_copy(16'h2000, 16'h2080, 255);
    check("max_lat", 32'(lat), 511);
    check("max_mem", 32'(mem_diff()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_copy_engine
